// File: rtl/tmds_pkg.sv
// TMDS definitions shared by the lane deserializer, token detector and decoder:
// control-token characters and aligner FSM state encodings.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTL0 = 10'h354;
    localparam logic [9:0] TMDS_CTL1 = 10'h0AB;
    localparam logic [9:0] TMDS_CTL2 = 10'h154;
    localparam logic [9:0] TMDS_CTL3 = 10'h2AB;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // Window offset advance; 9 wraps to 0, which is the same one-bit move mod 10.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_token_det.sv
// Flags a 10-bit TMDS character as one of the four control tokens sent during blanking.
module tmds_token_det
    import tmds_pkg::*;
(
    input  logic [9:0] data,
    output logic       is_token
);

    assign is_token = (data == TMDS_CTL0) || (data == TMDS_CTL1) ||
                      (data == TMDS_CTL2) || (data == TMDS_CTL3);

endmodule

// File: rtl/ser_to_par.sv
// 10:1 TMDS lane deserializer: rebuilds characters from DDR bit pairs and finds the
// character boundary by sliding a 10-bit window until a run of control tokens appears.
module ser_to_par
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 16,
    parameter int LOST_WORDS   = 4096
) (
    input  logic       clk_5x,
    input  logic       sys_rst_n,
    input  logic       ser_bit_h,
    input  logic       ser_bit_l,
    output logic [9:0] par_data,
    output logic       par_valid,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int WORD_W = $clog2(SEARCH_WORDS + 1);

    logic [19:0]       hist;
    logic [19:0]       hist_next;
    logic [4:0]        win_lo;
    logic [9:0]        cap_word;
    logic              capture;
    logic              is_token;
    logic [2:0]        phase;
    logic [1:0]        state;
    logic [TOK_W-1:0]  tok_cnt;
    logic [WORD_W-1:0] word_cnt;
    logic [11:0]       idle_cnt;

    // Low index is older on the wire; the window is taken from the post-shift history.
    assign hist_next = {ser_bit_l, ser_bit_h, hist[19:2]};
    assign win_lo    = {1'b0, bit_offset};
    assign cap_word  = hist_next[win_lo +: 10];
    assign capture   = (phase == 3'd4);

    tmds_token_det u_token_det (
        .data     (cap_word),
        .is_token (is_token)
    );

    // NOTE: the reset branch covers every register here; there is no storage array
    // that could be left unreset, so a single synchronous reset is sufficient.
    always_ff @(posedge clk_5x) begin
        if (!sys_rst_n) begin
            hist       <= '0;
            phase      <= '0;
            state      <= SEARCH;
            tok_cnt    <= '0;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            bit_offset <= '0;
            par_data   <= '0;
            par_valid  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every branch below see pre-edge values.
            hist      <= hist_next;
            par_valid <= capture;
            if (!capture) begin
                phase <= phase + 3'd1;
            end else begin
                phase    <= '0;
                par_data <= cap_word;
                case (state)
                    SEARCH: begin
                        if (is_token) begin
                            tok_cnt <= TOK_W'(1);
                            if (LOCK_TOKENS == 1) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                idle_cnt <= '0;
                            end else begin
                                state <= VERIFY;
                            end
                        end else if (word_cnt == WORD_W'(SEARCH_WORDS - 1)) begin
                            word_cnt   <= '0;
                            bit_offset <= next_offset(bit_offset);
                        end else begin
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (is_token) begin
                            tok_cnt <= tok_cnt + TOK_W'(1);
                            if (tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                idle_cnt <= '0;
                            end
                        end else begin
                            state      <= SEARCH;
                            tok_cnt    <= '0;
                            word_cnt   <= '0;
                            bit_offset <= next_offset(bit_offset);
                        end
                    end
                    LOCKED: begin
                        if (is_token) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == 12'(LOST_WORDS - 1)) begin
                            // Lock lost: keep the offset, the boundary is most likely still right.
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            tok_cnt  <= '0;
                            word_cnt <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 12'd1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_to_par.sv
// Randomized bench for ser_to_par: drives a wire-order bit stream and compares every
// cycle against a bit-stream/window reference model of the aligner.
module tb_ser_to_par;

    localparam int LOCK_TOKENS  = 8;
    localparam int SEARCH_WORDS = 16;
    localparam int LOST_WORDS   = 4096;
    localparam logic [9:0] IDLE_WORD = 10'h354;
    localparam logic [9:0] JUNK_WORD = 10'h1F0;

    typedef enum int {M_HUNT, M_CONFIRM, M_HOLD} mode_t;

    logic       clk_5x    = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       ser_bit_h = 1'b0;
    logic       ser_bit_l = 1'b0;
    logic [9:0] par_data;
    logic       par_valid;
    logic       locked;
    logic [3:0] bit_offset;

    ser_to_par #(
        .LOCK_TOKENS  (LOCK_TOKENS),
        .SEARCH_WORDS (SEARCH_WORDS),
        .LOST_WORDS   (LOST_WORDS)
    ) dut (
        .clk_5x     (clk_5x),
        .sys_rst_n  (sys_rst_n),
        .ser_bit_h  (ser_bit_h),
        .ser_bit_l  (ser_bit_l),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    always #5 clk_5x = ~clk_5x;

    int n_vec = 0;
    int n_bad = 0;

    // Pending transmit bits (wire order) and the last 20 received bits of the model.
    bit tx_q[$];
    bit rx_bits[$];

    int         m_phase;
    int         m_off;
    mode_t      m_mode;
    int         m_run;
    int         m_miss;
    int         m_idle;
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_locked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic bit is_ctl(input logic [9:0] w);
        return w inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
    endfunction

    function automatic logic [9:0] rand_word();
        logic [9:0] w;
        logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        if ($urandom_range(3) != 0) return toks[$urandom_range(3)];
        do w = 10'($urandom); while (is_ctl(w));
        return w;
    endfunction

    // Bits before reset release read as zero; window starts m_off bits above the oldest held bit.
    function automatic logic [9:0] window_word();
        logic [9:0] w;
        int base;
        base = rx_bits.size() - 20 + m_off;
        for (int i = 0; i < 10; i++)
            w[i] = (base + i >= 0) ? rx_bits[base + i] : 1'b0;
        return w;
    endfunction

    task automatic model_word(input logic [9:0] w);
        case (m_mode)
            M_HUNT: begin
                if (is_ctl(w)) begin
                    m_run = 1;
                    if (m_run >= LOCK_TOKENS) begin
                        m_mode = M_HOLD; m_idle = 0; m_locked = 1'b1;
                    end else begin
                        m_mode = M_CONFIRM;
                    end
                end else begin
                    m_miss++;
                    if (m_miss == SEARCH_WORDS) begin
                        m_miss = 0;
                        m_off  = (m_off + 1) % 10;
                    end
                end
            end
            M_CONFIRM: begin
                if (is_ctl(w)) begin
                    m_run++;
                    if (m_run == LOCK_TOKENS) begin
                        m_mode = M_HOLD; m_idle = 0; m_locked = 1'b1;
                    end
                end else begin
                    m_off  = (m_off + 1) % 10;
                    m_run  = 0;
                    m_miss = 0;
                    m_mode = M_HUNT;
                end
            end
            default: begin
                if (is_ctl(w)) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == LOST_WORDS) begin
                        m_mode = M_HUNT; m_locked = 1'b0;
                        m_idle = 0; m_run = 0; m_miss = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic model_step(input logic r, input logic h, input logic l);
        if (!r) begin
            rx_bits.delete();
            m_phase = 0; m_off = 0; m_mode = M_HUNT;
            m_run = 0; m_miss = 0; m_idle = 0;
            m_data = '0; m_valid = 1'b0; m_locked = 1'b0;
        end else begin
            rx_bits.push_back(h);
            rx_bits.push_back(l);
            while (rx_bits.size() > 20) void'(rx_bits.pop_front());
            m_valid = 1'b0;
            if (m_phase == 4) begin
                m_phase = 0;
                m_data  = window_word();
                m_valid = 1'b1;
                model_word(m_data);
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic h, input logic l);
        @(negedge clk_5x);
        sys_rst_n = r;
        ser_bit_h = h;
        ser_bit_l = l;
        @(posedge clk_5x);
        #1;
        model_step(r, h, l);
        check("outs{data,valid,locked,offset}",
              32'({par_data, par_valid, locked, bit_offset}),
              32'({m_data, m_valid, m_locked, 4'(m_off)}));
    endtask

    task automatic do_reset(input int n);
        tx_q.delete();
        repeat (n) cycle(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) tx_q.push_back(w[i]);
    endtask

    task automatic drain();
        bit h, l;
        while (tx_q.size() >= 2) begin
            h = tx_q.pop_front();
            l = tx_q.pop_front();
            cycle(1'b1, h, l);
        end
    endtask

    task automatic send(input logic [9:0] w);
        push_word(w);
        drain();
    endtask

    task automatic wait_lock(input int max_words, input string tag);
        int k;
        k = 0;
        while (!locked && k < max_words) begin
            send(IDLE_WORD);
            k++;
        end
        check(tag, 32'(locked), 32'd1);
    endtask

    initial begin
        int first_valid;
        bit h, l;

        // Reset values, then first strobe five cycles after release.
        do_reset(3);
        check("rst_par_data",   32'(par_data),   32'd0);
        check("rst_par_valid",  32'(par_valid),  32'd0);
        check("rst_locked",     32'(locked),     32'd0);
        check("rst_bit_offset", 32'(bit_offset), 32'd0);
        first_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'($urandom), 1'($urandom));
            if (par_valid && first_valid == 0) first_valid = k;
        end
        check("first_valid_cycle", 32'(first_valid), 32'd5);

        // Aligned lock: capture 1 sees only reset zeros, tokens from capture 2, lock on capture 9.
        do_reset(2);
        for (int k = 1; k <= 9; k++) begin
            send(IDLE_WORD);
            check("aligned_lock_edge", 32'(locked), 32'(k >= 9));
        end
        check("aligned_offset", 32'(bit_offset), 32'd0);
        for (int k = 0; k < 4; k++) begin
            send(IDLE_WORD);
            check("aligned_data", 32'(par_data), 32'(IDLE_WORD));
        end

        // Random token/non-token mix on an aligned stream.
        for (int k = 0; k < 150; k++) send(rand_word());

        // Skewed lock: stream delayed by 3 bits.
        do_reset(2);
        repeat (3) tx_q.push_back(1'b0);
        wait_lock(10 * SEARCH_WORDS + LOCK_TOKENS + 4, "skew_lock");
        check("skew_offset", 32'(bit_offset), 32'd3);
        for (int k = 0; k < 20; k++) send(IDLE_WORD);
        check("skew_offset_stable", 32'(bit_offset), 32'd3);
        check("skew_still_locked",  32'(locked),     32'd1);

        // VERIFY abort: 5 tokens then 10'h1F0 (seen one capture after it is sent).
        do_reset(2);
        repeat (5) send(IDLE_WORD);
        send(JUNK_WORD);
        check("abort_pre_offset", 32'(bit_offset), 32'd0);
        send(JUNK_WORD);
        check("abort_no_lock", 32'(locked),     32'd0);
        check("abort_offset",  32'(bit_offset), 32'd1);
        repeat (16) send(JUNK_WORD);
        check("abort_back_in_search", 32'(bit_offset), 32'd2);

        // Lock loss after LOST_WORDS consecutive non-tokens, offset kept.
        do_reset(2);
        repeat (10) send(IDLE_WORD);
        check("loss_pre_locked", 32'(locked), 32'd1);
        send(JUNK_WORD);
        for (int i = 1; i <= LOST_WORDS; i++) begin
            send(rand_word() & 10'h3F0 | 10'h00F);
            if (i == LOST_WORDS - 1) check("loss_hold_4095", 32'(locked), 32'd1);
            if (i == LOST_WORDS) begin
                check("loss_drop_4096", 32'(locked),     32'd0);
                check("loss_offset",    32'(bit_offset), 32'd0);
            end
        end

        // A single token inside a long idle run keeps the lock.
        wait_lock(40, "hold_relock");
        repeat (2000) send(JUNK_WORD);
        send(IDLE_WORD);
        repeat (4000) send(JUNK_WORD);
        check("hold_token_resets_idle", 32'(locked), 32'd1);

        // Mid-run reset while locked at offset 7, then relock.
        do_reset(2);
        repeat (7) tx_q.push_back(1'b0);
        wait_lock(200, "mid_prelock");
        check("mid_offset", 32'(bit_offset), 32'd7);
        push_word(IDLE_WORD);
        repeat (2) begin
            h = tx_q.pop_front();
            l = tx_q.pop_front();
            cycle(1'b1, h, l);
        end
        h = tx_q.pop_front();
        l = tx_q.pop_front();
        cycle(1'b0, h, l);
        check("mid_rst_locked", 32'(locked),     32'd0);
        check("mid_rst_offset", 32'(bit_offset), 32'd0);
        check("mid_rst_valid",  32'(par_valid),  32'd0);
        drain();
        wait_lock(200, "mid_relock");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
